// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Operation select values and FSM states.
package muldiv_pkg;

   typedef enum logic [1:0] {
      MULTU = 2'b00,
      MULT  = 2'b01,
      DIVU  = 2'b10,
      DIV   = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One shift-add or restoring subtract-shift step per cycle; signed ops work on magnitudes.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             hiWr,
   input  logic             loWr,
   input  logic [WIDTH-1:0] wrData,
   output logic             busy,
   output logic             done,
   output logic             divZero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   state_e           state_q;
   op_e              op_q;
   logic [WIDTH-1:0] acc_q, sr_q, b_q, hi_q, lo_q;
   logic [CW-1:0]    cnt_q;
   logic             neg_res_q, neg_rem_q, busy_q, done_q, dz_q;

   op_e              op_in;
   logic             in_signed, in_div, a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic             is_div, div_ge;
   logic [WIDTH:0]   mul_sum, div_sh, div_diff;
   logic [WIDTH-1:0] step_acc_d, step_sr_d, quo, rem, res_hi_d, res_lo_d;
   logic [2*WIDTH-1:0] prod;

   always_comb begin
      op_in     = op_e'(op);
      in_signed = (op_in == MULT) || (op_in == DIV);
      in_div    = (op_in == DIVU) || (op_in == DIV);
      a_neg     = in_signed & A[WIDTH-1];
      b_neg     = in_signed & B[WIDTH-1];
      a_mag     = a_neg ? -A : A;
      b_mag     = b_neg ? -B : B;
   end

   // acc_q holds the running high product / partial remainder; sr_q the low product / quotient.
   always_comb begin
      is_div   = (op_q == DIVU) || (op_q == DIV);
      mul_sum  = {1'b0, acc_q} + (sr_q[0] ? {1'b0, b_q} : '0);
      div_sh   = {acc_q, sr_q[WIDTH-1]};
      div_diff = div_sh - {1'b0, b_q};
      div_ge   = ~div_diff[WIDTH];
      if (is_div) begin
         step_acc_d = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
         step_sr_d  = {sr_q[WIDTH-2:0], div_ge};
      end else begin
         step_acc_d = mul_sum[WIDTH:1];
         step_sr_d  = {mul_sum[0], sr_q[WIDTH-1:1]};
      end
      prod = {step_acc_d, step_sr_d};
      if (neg_res_q) prod = -prod;
      quo = neg_res_q ? -step_sr_d : step_sr_d;
      rem = neg_rem_q ? -step_acc_d : step_acc_d;
      if (is_div) begin
         res_hi_d = rem;
         res_lo_d = quo;
      end else begin
         res_hi_d = prod[2*WIDTH-1:WIDTH];
         res_lo_d = prod[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         op_q      <= MULTU;
         acc_q     <= '0;
         sr_q      <= '0;
         b_q       <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         cnt_q     <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dz_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  op_q      <= op_in;
                  acc_q     <= '0;
                  sr_q      <= a_mag;
                  b_q       <= b_mag;
                  cnt_q     <= '0;
                  neg_res_q <= a_neg ^ b_neg;
                  neg_rem_q <= a_neg & in_div;
                  busy_q    <= 1'b1;
                  dz_q      <= 1'b0;
                  if (in_div && (B == '0)) begin
                     state_q <= DONE;
                     hi_q    <= A;
                     lo_q    <= '1;
                     dz_q    <= 1'b1;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= RUN;
                  end
               end else begin
                  if (hiWr) hi_q <= wrData;
                  if (loWr) lo_q <= wrData;
               end
            end
            RUN: begin
               acc_q <= step_acc_d;
               sr_q  <= step_sr_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state_q <= DONE;
                  hi_q    <= res_hi_d;
                  lo_q    <= res_lo_d;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign divZero = dz_q;
   assign hi      = hi_q;
   assign lo      = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH = 32).
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] A, B, wrData;
   logic        hiWr, loWr;
   logic        busy, done, divZero;
   logic [31:0] hi, lo;

   int checks   = 0;
   int failures = 0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
      .hiWr(hiWr), .loWr(loWr), .wrData(wrData),
      .busy(busy), .done(done), .divZero(divZero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   // Caller is at a negedge; start is seen by the next rising edge, returns at cycle 1.
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      op = o; A = a; B = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0; A = 32'h5A5A5A5A; B = 32'h0F0F0F0F; op = 2'b00;
   endtask

   // Returns the cycle number (counted from the start cycle) at which done is seen, or -1.
   task automatic wait_done(input int from, output int lat);
      lat = from;
      while (done !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      if (done !== 1'b1) lat = -1;
   endtask

   task automatic test_reset;
      rst = 1'b0; start = 1'b0; op = 2'b00; A = '0; B = '0;
      hiWr = 1'b0; loWr = 1'b0; wrData = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, divZero} !== 3'b000 || hi !== 32'h0 || lo !== 32'h0) begin
         failures++;
         $display("FAIL reset_state: busy/done/dz=%b%b%b hi=%h lo=%h, expected 000 0 0",
                  busy, done, divZero, hi, lo);
      end
      rst = 1'b1;
   endtask

   task automatic test_multu;
      int lat;
      issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL multu_busy: busy=%b expected 1", busy);
      end
      wait_done(1, lat);
      checks++;
      if (lat != 33) begin
         failures++;
         $display("FAIL multu_latency: done at cycle %0d expected 33", lat);
      end
      checks++;
      if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
         failures++;
         $display("FAIL multu_result: hi=%h lo=%h expected FFFFFFFE 00000001", hi, lo);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL multu_idle: busy=%b done=%b expected 0 0", busy, done);
      end
   endtask

   task automatic test_signed;
      logic [1:0]  t_op [6] = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b10, 2'b00};
      logic [31:0] t_a  [6] = '{32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFF9, 32'h00000007,
                                32'h00000064, 32'h12345678};
      logic [31:0] t_b  [6] = '{32'h00000005, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE,
                                32'h00000007, 32'h00000010};
      logic [31:0] e_hi [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,
                                32'h00000002, 32'h00000001};
      logic [31:0] e_lo [6] = '{32'hFFFFFFF1, 32'hFFFFFFF9, 32'hFFFFFFFD, 32'hFFFFFFFD,
                                32'h0000000E, 32'h23456780};
      int lat;
      for (int i = 0; i < 6; i++) begin
         issue(t_op[i], t_a[i], t_b[i]);
         wait_done(1, lat);
         checks++;
         if (lat != 33 || hi !== e_hi[i] || lo !== e_lo[i] || divZero !== 1'b0) begin
            failures++;
            $display("FAIL op_vector_%0d: lat=%0d hi=%h lo=%h dz=%b expected 33 %h %h 0",
                     i, lat, hi, lo, divZero, e_hi[i], e_lo[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_divzero;
      int lat;
      issue(2'b10, 32'h00000064, 32'h00000000);
      wait_done(1, lat);
      checks++;
      if (lat != 1 || divZero !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL divzero_timing: lat=%0d dz=%b busy=%b expected 1 1 1", lat, divZero, busy);
      end
      checks++;
      if (hi !== 32'h00000064 || lo !== 32'hFFFFFFFF) begin
         failures++;
         $display("FAIL divzero_result: hi=%h lo=%h expected 00000064 FFFFFFFF", hi, lo);
      end
      @(negedge clk);
      checks++;
      if (divZero !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL divzero_hold: dz=%b busy=%b done=%b expected 1 0 0", divZero, busy, done);
      end
   endtask

   task automatic test_div_overflow;
      int lat;
      issue(2'b11, 32'h80000000, 32'hFFFFFFFF);
      checks++;
      if (divZero !== 1'b0) begin
         failures++;
         $display("FAIL dz_clear_on_start: dz=%b expected 0", divZero);
      end
      wait_done(1, lat);
      checks++;
      if (lat != 33 || lo !== 32'h80000000 || hi !== 32'h0 || divZero !== 1'b0) begin
         failures++;
         $display("FAIL div_overflow: lat=%0d hi=%h lo=%h dz=%b expected 33 00000000 80000000 0",
                  lat, hi, lo, divZero);
      end
      @(negedge clk);
   endtask

   task automatic test_busy_ignore;
      int lat;
      int extra_done = 0;
      hiWr = 1'b1; wrData = 32'hAAAA0000;
      @(negedge clk);
      hiWr = 1'b0; loWr = 1'b1; wrData = 32'h0000BBBB;
      @(negedge clk);
      loWr = 1'b0;
      issue(2'b01, 32'hFFFFFFFD, 32'h00000005);
      repeat (4) @(negedge clk);
      op = 2'b00; A = 32'h2; B = 32'h3; start = 1'b1; hiWr = 1'b1; wrData = 32'hDEADBEEF;
      @(negedge clk);
      start = 1'b0; hiWr = 1'b0;
      checks++;
      if (busy !== 1'b1 || hi !== 32'hAAAA0000 || lo !== 32'h0000BBBB) begin
         failures++;
         $display("FAIL busy_hold: busy=%b hi=%h lo=%h expected 1 AAAA0000 0000BBBB", busy, hi, lo);
      end
      wait_done(6, lat);
      checks++;
      if (lat != 33 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin
         failures++;
         $display("FAIL busy_ignore_result: lat=%0d hi=%h lo=%h expected 33 FFFFFFFF FFFFFFF1",
                  lat, hi, lo);
      end
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) extra_done++;
      end
      checks++;
      if (extra_done != 0) begin
         failures++;
         $display("FAIL no_queued_start: %0d busy/done cycles seen expected 0", extra_done);
      end
   endtask

   task automatic test_reset_abort;
      int lat;
      int seen = 0;
      issue(2'b10, 32'h00000064, 32'h00000007);
      repeat (9) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
         failures++;
         $display("FAIL reset_abort: busy=%b done=%b hi=%h lo=%h expected 0 0 0 0", busy, done, hi, lo);
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) seen++;
      end
      checks++;
      if (seen != 0 || hi !== 32'h0 || lo !== 32'h0) begin
         failures++;
         $display("FAIL abort_no_commit: done pulses=%0d hi=%h lo=%h expected 0 0 0", seen, hi, lo);
      end
      issue(2'b10, 32'h00000064, 32'h00000007);
      wait_done(1, lat);
      checks++;
      if (lat != 33 || hi !== 32'h2 || lo !== 32'hE) begin
         failures++;
         $display("FAIL after_abort: lat=%0d hi=%h lo=%h expected 33 00000002 0000000E", lat, hi, lo);
      end
      @(negedge clk);
   endtask

   task automatic test_mthi_mtlo;
      int lat;
      hiWr = 1'b1; loWr = 1'b1; wrData = 32'h11111111;
      @(negedge clk);
      hiWr = 1'b0; loWr = 1'b0;
      checks++;
      if (hi !== 32'h11111111 || lo !== 32'h11111111) begin
         failures++;
         $display("FAIL both_write: hi=%h lo=%h expected 11111111 11111111", hi, lo);
      end
      hiWr = 1'b1; wrData = 32'h12345678;
      @(negedge clk);
      hiWr = 1'b0;
      checks++;
      if (hi !== 32'h12345678 || lo !== 32'h11111111) begin
         failures++;
         $display("FAIL mthi: hi=%h lo=%h expected 12345678 11111111", hi, lo);
      end
      loWr = 1'b1; wrData = 32'hCAFEF00D;
      issue(2'b00, 32'h00000003, 32'h00000004);
      loWr = 1'b0;
      checks++;
      if (busy !== 1'b1 || hi !== 32'h12345678 || lo !== 32'h11111111) begin
         failures++;
         $display("FAIL mtlo_with_start: busy=%b hi=%h lo=%h expected 1 12345678 11111111", busy, hi, lo);
      end
      loWr = 1'b1; wrData = 32'h0BADF00D;
      @(negedge clk);
      loWr = 1'b0;
      checks++;
      if (lo !== 32'h11111111) begin
         failures++;
         $display("FAIL mtlo_while_busy: lo=%h expected 11111111", lo);
      end
      wait_done(2, lat);
      checks++;
      if (lat != 33 || hi !== 32'h0 || lo !== 32'h0000000C) begin
         failures++;
         $display("FAIL mtlo_op_result: lat=%0d hi=%h lo=%h expected 33 00000000 0000000C", lat, hi, lo);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset;
      test_multu;
      test_signed;
      test_divzero;
      test_div_overflow;
      test_busy_ignore;
      test_reset_abort;
      test_mthi_mtlo;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
